// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through, no-write-allocate data cache.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_ctrl #(
  parameter int LINES     = 16,
  parameter int WORDS     = 4,
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        M_re_i,
  input  logic        M_we_i,
  input  logic [63:0] M_addr_i,
  input  logic [63:0] M_wdata_i,
  output logic [63:0] m_rdata_o,
  output logic        m_error_o,
  output logic        h_cache_access_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_err_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int LB = 3 + WB;
  localparam int TB = 64 - LB - IB;
  localparam logic [63:0] LAST = 64'(MEM_BYTES) - 64'd8;

  typedef enum logic [1:0] {
    IDLE, REFILL, WRITE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TB-1:0]    tag_q  [LINES];
  logic [63:0]      data_q [LINES][WORDS];

  logic [WB-1:0] beat_q;
  logic [63:0]   cap_q;
  logic [63:0]   wdata_q;
  logic          err_q;

  logic [WB-1:0] a_word;
  logic [IB-1:0] a_idx;
  logic [TB-1:0] a_tag;
  logic [WB-1:0] c_word;
  logic [IB-1:0] c_idx;
  logic [TB-1:0] c_tag;

  assign a_word = M_addr_i[3 +: WB];
  assign a_idx  = M_addr_i[LB +: IB];
  assign a_tag  = M_addr_i[63 -: TB];
  assign c_word = cap_q[3 +: WB];
  assign c_idx  = cap_q[LB +: IB];
  assign c_tag  = cap_q[63 -: TB];

  logic acc, illegal, legal, hit;
  logic idle, rd_miss, wr;
  logic rf_ack, wr_ack, last_beat;

  assign acc     = M_re_i | M_we_i;
  assign illegal = (|M_addr_i[2:0]) | (M_addr_i > LAST);
  assign legal   = acc & ~illegal;
  assign hit     = valid_q[a_idx] & (tag_q[a_idx] == a_tag);
  assign idle    = (state_q == IDLE);
  assign rd_miss = idle & M_re_i & legal & ~hit;
  assign wr      = idle & M_we_i & legal;

  assign rf_ack    = (state_q == REFILL) & mem_ack_i;
  assign wr_ack    = (state_q == WRITE) & mem_ack_i;
  assign last_beat = (beat_q == WB'(WORDS - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_miss)  state_d = REFILL;
        else if (wr)  state_d = WRITE;
      end
      REFILL: begin
        if (mem_ack_i) begin
          if (mem_err_i)      state_d = DONE;
          else if (last_beat) state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack_i) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_rdata_o        = '0;
    m_error_o        = 1'b0;
    h_cache_access_o = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    unique case (state_q)
      IDLE: begin
        m_error_o        = acc & illegal;
        h_cache_access_o = rd_miss | wr;
        if (M_re_i & legal)
          m_rdata_o = data_q[a_idx][a_word];
      end
      REFILL: begin
        h_cache_access_o = 1'b1;
        mem_req_o        = 1'b1;
        mem_addr_o       = cap_q | 64'({beat_q, 3'b000});
      end
      WRITE: begin
        h_cache_access_o = 1'b1;
        mem_req_o        = 1'b1;
        mem_we_o         = 1'b1;
        mem_addr_o       = cap_q;
        mem_wdata_o      = wdata_q;
      end
      DONE: m_error_o = err_q;
    endcase
  end

  // The target line is invalidated at miss start so a partial or
  // aborted refill can never be reported as a hit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      beat_q  <= '0;
      cap_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rd_miss) begin
        cap_q          <= {M_addr_i[63:LB], {LB{1'b0}}};
        beat_q         <= '0;
        valid_q[a_idx] <= 1'b0;
      end
      if (wr) begin
        cap_q   <= M_addr_i;
        wdata_q <= M_wdata_i;
      end
      if (rf_ack) begin
        beat_q <= beat_q + 1'b1;
        if (mem_err_i)      err_q          <= 1'b1;
        else if (last_beat) valid_q[c_idx] <= 1'b1;
      end
      if (wr_ack) err_q <= mem_err_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rf_ack & ~mem_err_i) begin
      data_q[c_idx][beat_q] <= mem_rdata_i;
      if (last_beat) tag_q[c_idx] <= c_tag;
    end
    if (wr_ack & valid_q[c_idx] & (tag_q[c_idx] == c_tag))
      data_q[c_idx][c_word] <= wdata_q;
  end

`ifdef DCACHE_STATS_EN
  logic rd_hit;
  assign rd_hit = idle & M_re_i & legal & hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (rd_hit && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (rd_miss && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
